iterative_alu: RTL and testbench
================================

# iterative_alu

Parametrised, clocked successor to the datapath's combinational ALU. Accepts one operation per Start handshake, executes single-step ops in one cycle and shift/mask ops iteratively (one bit position per cycle), then presents a registered result with status flags and a one-cycle Done pulse. Sits between the register file read ports and the writeback mux; the controller stalls on Busy.

## Interface
Parameters:
- W, 8, datapath width; legal values 8, 16, 32.
- OPS, 4, opcode width.
- SHW, $clog2(W), shift-amount width (derived; not overridden).

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- Start  in  1  request; accepted on a rising edge when Busy==0.
- InputA  in  W  operand A.
- InputB  in  W  operand B.
- Immediate  in  5  immediate field.
- OP  in  OPS  opcode, sampled with Start.
- SC_in  in  1  carry in (ADC only).
- Busy  out  1  high in RUN state.
- Done  out  1  one-cycle pulse: result valid.
- Out  out  W  registered result, held until the next accepted Start completes.
- Carry  out  1  registered carry/shift-out flag.
- Err  out  1  registered: last op was illegal.
- Zero, Parity, Odd  out  1  combinational from Out: ~|Out, ^Out, Out[0].

## Operation
- Opcodes: ADD=0, LSL=1, LSR=2, XOR=3, SNE=4, SEQ=5, MSK=6, ADC=7, ROL=8, ROR=9 (8/9 only with macro); all others illegal.
- Shift amount n: Immediate[SHW-1:0] for LSL/LSR/ROL/ROR; InputB[SHW-1:0] for MSK; n=0 for all others.
- ADD: {Carry,Out} = InputA + zero-extended Immediate (full 5 bits).
- ADC: {Carry,Out} = InputA + InputB + SC_in.
- XOR: Out = InputA ^ InputB; Carry=0.
- SNE/SEQ: compare InputA with zero-extended Immediate; Out = 1 or 0 (W-bit); Carry=0.
- LSL/LSR: zero-fill shift by n; Carry = last bit shifted out, 0 if n=0.
- MSK: Out = 1 << n (one-hot); Carry=0.
- ROL/ROR: rotate by n; Carry = last bit rotated across the end, 0 if n=0.
- Illegal: Out=0, Carry=0, Err=1, one-cycle latency. Err cleared by the next legal op's completion.
- FSM: IDLE, RUN, DONE.
  - IDLE/DONE + Start: latch operands and OP into working register, Cnt<=n, go RUN.
  - IDLE/DONE without Start: go/stay IDLE (DONE lasts exactly one cycle).
  - RUN, Cnt!=0: one bit step on working register, update shift-out bit, Cnt<=Cnt-1.
  - RUN, Cnt==0: single-step ops compute here; commit Out/Carry/Err; go DONE.
- Start while Busy: ignored, no side effects; operands need not be held after acceptance.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, Busy=0, Done=0, Out=0, Carry=0, Err=0; therefore Zero=1, Parity=0, Odd=0.
- Accept edge k: Busy high from edge k through edge k+1+n; Out/Carry/Err update at edge k+1+n; Done high for the cycle following edge k+1+n.
- Latency n+1 edges; n=0 ops complete in 1 edge; maximum W edges (n=W-1).
- Back-to-back: Start during the DONE cycle is accepted; no idle bubble.
- Reset asserted mid-RUN: operation discarded, no Done, all outputs to reset values immediately.
- Out stable between completions; flags change only at commit edges.

## Configuration
- ALU_ROTATE_EN defined: ROL (8) and ROR (9) legal as above.
- Not defined: opcodes 8 and 9 illegal (Out=0, Err=1, 1-edge latency); no rotate hardware synthesised.

## Test plan
- Reset: Reset_n low mid-LSL with n=5 -> Busy=0, Done never pulses, Out=0, Zero=1 immediately; after release, idle.
- ADD W=8: A=8'hFE, Immediate=5 -> Out=8'h03, Carry=1, Done 1 edge after accept; ADC A=8'h7F, B=8'h00, SC_in=1 -> Out=8'h80, Carry=0, Parity=1.
- LSL A=8'h81, Immediate=3 -> Busy 4 edges, Out=8'h08, Carry=0; LSR A=8'h81, Immediate=1 -> Out=8'h40, Carry=1.
- MSK B=8'h06 -> Out=8'h40; SEQ A=8'h11, Immediate=17 -> Out=1; SNE same -> Out=0, Zero=1.
- Start pulsed every cycle during LSL n=7 with different OP -> only first op executes, Out per first op, then back-to-back accept in DONE cycle.
- OP=8, A=8'h81, Immediate=1: with ALU_ROTATE_EN -> Out=8'h03, Carry=1; without -> Out=0, Err=1; OP=15 -> Err=1 in both builds.

Source files
------------

// File: rtl/iterative_alu.sv
// iterative_alu: clocked ALU; shift and mask ops advance one bit position per clock.
// Define ALU_ROTATE_EN to make ROL (8) and ROR (9) legal; otherwise they decode as illegal.
module iterative_alu #(
  parameter  int W   = 8,
  parameter  int OPS = 4,
  localparam int SHW = $clog2(W)
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           Start,
  input  logic [W-1:0]   InputA,
  input  logic [W-1:0]   InputB,
  input  logic [4:0]     Immediate,
  input  logic [OPS-1:0] OP,
  input  logic           SC_in,
  output logic           Busy,
  output logic           Done,
  output logic [W-1:0]   Out,
  output logic           Carry,
  output logic           Err,
  output logic           Zero,
  output logic           Parity,
  output logic           Odd
);

  localparam logic [OPS-1:0] OP_ADD = OPS'(0);
  localparam logic [OPS-1:0] OP_LSL = OPS'(1);
  localparam logic [OPS-1:0] OP_LSR = OPS'(2);
  localparam logic [OPS-1:0] OP_XOR = OPS'(3);
  localparam logic [OPS-1:0] OP_SNE = OPS'(4);
  localparam logic [OPS-1:0] OP_SEQ = OPS'(5);
  localparam logic [OPS-1:0] OP_MSK = OPS'(6);
  localparam logic [OPS-1:0] OP_ADC = OPS'(7);
`ifdef ALU_ROTATE_EN
  localparam logic [OPS-1:0] OP_ROL = OPS'(8);
  localparam logic [OPS-1:0] OP_ROR = OPS'(9);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [OPS-1:0] op_q,    op_d;
  logic [W-1:0]   work_q,  work_d;
  logic [W-1:0]   b_q,     b_d;
  logic [4:0]     imm_q,   imm_d;
  logic           sc_q,    sc_d;
  logic [SHW-1:0] cnt_q,   cnt_d;
  logic           shout_q, shout_d;
  logic [W-1:0]   out_q,   out_d;
  logic           carry_q, carry_d;
  logic           err_q,   err_d;
  logic           busy_q,  busy_d;
  logic           done_q,  done_d;

  logic [W-1:0]   imm_ext;
  logic [W:0]     sum;

  // Number of single-bit steps an opcode needs before it can commit.
  function automatic logic [SHW-1:0] shift_amount(input logic [OPS-1:0] op,
                                                  input logic [4:0]     imm,
                                                  input logic [W-1:0]   b);
    shift_amount = '0;
    case (op)
      OP_LSL, OP_LSR: shift_amount = imm[SHW-1:0];
`ifdef ALU_ROTATE_EN
      OP_ROL, OP_ROR: shift_amount = imm[SHW-1:0];
`endif
      OP_MSK:         shift_amount = b[SHW-1:0];
      default:        shift_amount = '0;
    endcase
  endfunction

  assign imm_ext = {{(W-5){1'b0}}, imm_q};
  assign sum     = (op_q == OP_ADC) ? ({1'b0, work_q} + {1'b0, b_q} + {{W{1'b0}}, sc_q})
                                    : ({1'b0, work_q} + {1'b0, imm_ext});

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    b_d     = b_q;
    imm_d   = imm_q;
    sc_d    = sc_q;
    cnt_d   = cnt_q;
    shout_d = shout_q;
    out_d   = out_q;
    carry_d = carry_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          op_d    = OP;
          // MSK walks a single one up from bit 0 rather than shifting operand A.
          work_d  = (OP == OP_MSK) ? W'(1) : InputA;
          b_d     = InputB;
          imm_d   = Immediate;
          sc_d    = SC_in;
          cnt_d   = shift_amount(OP, Immediate, InputB);
          shout_d = 1'b0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SHW'(1);
          case (op_q)
            OP_LSL, OP_MSK: begin
              shout_d = work_q[W-1];
              work_d  = {work_q[W-2:0], 1'b0};
            end
            OP_LSR: begin
              shout_d = work_q[0];
              work_d  = {1'b0, work_q[W-1:1]};
            end
`ifdef ALU_ROTATE_EN
            OP_ROL: begin
              shout_d = work_q[W-1];
              work_d  = {work_q[W-2:0], work_q[W-1]};
            end
            OP_ROR: begin
              shout_d = work_q[0];
              work_d  = {work_q[0], work_q[W-1:1]};
            end
`endif
            default: begin
              shout_d = shout_q;
              work_d  = work_q;
            end
          endcase
        end else begin
          out_d   = '0;
          carry_d = 1'b0;
          err_d   = 1'b0;
          case (op_q)
            OP_ADD, OP_ADC: {carry_d, out_d} = sum;
            OP_XOR:         out_d = work_q ^ b_q;
            OP_SNE:         out_d = (work_q != imm_ext) ? W'(1) : '0;
            OP_SEQ:         out_d = (work_q == imm_ext) ? W'(1) : '0;
            OP_LSL, OP_LSR: begin
              out_d   = work_q;
              carry_d = shout_q;
            end
`ifdef ALU_ROTATE_EN
            OP_ROL, OP_ROR: begin
              out_d   = work_q;
              carry_d = shout_q;
            end
`endif
            OP_MSK:         out_d = work_q;
            default:        err_d = 1'b1;
          endcase
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      work_q  <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      sc_q    <= 1'b0;
      cnt_q   <= '0;
      shout_q <= 1'b0;
      out_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      sc_q    <= sc_d;
      cnt_q   <= cnt_d;
      shout_q <= shout_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Out    = out_q;
  assign Carry  = carry_q;
  assign Err    = err_q;
  assign Zero   = ~|out_q;
  assign Parity = ^out_q;
  assign Odd    = out_q[0];

endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: randomized and directed stimulus, scoreboard queue fed by the driver and
// drained by a monitor on each Done pulse; expectations come from an arithmetic reference model.
module tb_iterative_alu;

  localparam int W   = 8;
  localparam int OPS = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a_in, b_in;
  logic [4:0]     imm_in;
  logic [OPS-1:0] op_in;
  logic           sc_in;
  logic           busy, done, carry, err, zero, parity, odd;
  logic [W-1:0]   out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [W-1:0] out;
    logic         carry;
    logic         err;
    int           n;
    int           done_cyc;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  logic [W-1:0] last_out;
  logic         last_carry, last_err;

  iterative_alu #(.W(W), .OPS(OPS)) dut (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .InputA(a_in), .InputB(b_in),
    .Immediate(imm_in), .OP(op_in), .SC_in(sc_in), .Busy(busy), .Done(done),
    .Out(out), .Carry(carry), .Err(err), .Zero(zero), .Parity(parity), .Odd(odd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: result computed directly from the opcode definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [4:0] imm, input logic sc);
    exp_t   r;
    longint s;
    r.out = '0; r.carry = 1'b0; r.err = 1'b0; r.n = 0; r.done_cyc = 0;
    case (op)
      4'd0: begin s = longint'(a) + longint'(imm); r.out = W'(s); r.carry = s[W]; end
      4'd1: begin r.n = int'(imm) % W; r.out = a << r.n; r.carry = (r.n == 0) ? 1'b0 : a[W - r.n]; end
      4'd2: begin r.n = int'(imm) % W; r.out = a >> r.n; r.carry = (r.n == 0) ? 1'b0 : a[r.n - 1]; end
      4'd3: r.out = a ^ b;
      4'd4: r.out = (a != W'(imm)) ? W'(1) : '0;
      4'd5: r.out = (a == W'(imm)) ? W'(1) : '0;
      4'd6: begin r.n = int'(b) % W; r.out = W'(1) << r.n; end
      4'd7: begin s = longint'(a) + longint'(b) + longint'(sc); r.out = W'(s); r.carry = s[W]; end
`ifdef ALU_ROTATE_EN
      4'd8: begin
        r.n = int'(imm) % W;
        r.out = (r.n == 0) ? a : ((a << r.n) | (a >> (W - r.n)));
        r.carry = (r.n == 0) ? 1'b0 : r.out[0];
      end
      4'd9: begin
        r.n = int'(imm) % W;
        r.out = (r.n == 0) ? a : ((a >> r.n) | (a << (W - r.n)));
        r.carry = (r.n == 0) ? 1'b0 : r.out[W-1];
      end
`endif
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  // Monitor: pops on every Done, otherwise checks that the committed result is held.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_out = '0; last_carry = 1'b0; last_err = 1'b0;
    end else if (done) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_done: Done=1 with no pending op (cycle %0d)", cyc);
      end else begin
        mon_e = q.pop_front();
        check("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
        check("out", 64'(out), 64'(mon_e.out));
        check("carry", 64'(carry), 64'(mon_e.carry));
        check("err", 64'(err), 64'(mon_e.err));
        check("zero", 64'(zero), 64'(mon_e.out == '0));
        check("parity", 64'(parity), 64'(^mon_e.out));
        check("odd", 64'(odd), 64'(mon_e.out[0]));
        last_out = mon_e.out; last_carry = mon_e.carry; last_err = mon_e.err;
      end
    end else begin
      check("out_hold", 64'(out), 64'(last_out));
      check("carry_hold", 64'(carry), 64'(last_carry));
      check("err_hold", 64'(err), 64'(last_err));
    end
  end

  // Drive one cycle from a negedge; an accepted Start pushes its expectation.
  task automatic step(input logic st, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [4:0] imm, input logic sc);
    exp_t e;
    start = st; op_in = op; a_in = a; b_in = b; imm_in = imm; sc_in = sc;
    if (st && !busy) begin
      e = model(op, a, b, imm, sc);
      e.done_cyc = cyc + 2 + e.n;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, op_in, a_in, b_in, imm_in, sc_in);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] imm, input logic sc);
    int guard = 0;
    while (busy && guard < 64) begin
      step(1'b0, op, a, b, imm, sc);
      guard++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL issue_timeout: Busy still high after %0d cycles", guard);
    end
    step(1'b1, op, a, b, imm, sc);
    start = 1'b0;
    check("busy_after_accept", 64'(busy), 64'(1));
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || q.size() != 0) && guard < 64) begin
      idle();
      guard++;
    end
    if (busy || q.size() != 0) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d", busy, q.size());
    end
  endtask

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic [4:0]   imm;

    rst_n = 1'b0; start = 1'b0; op_in = '0; a_in = '0; b_in = '0; imm_in = '0; sc_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_out", 64'(out), 64'(0));
    check("rst_carry", 64'(carry), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_zero", 64'(zero), 64'(1));
    check("rst_parity", 64'(parity), 64'(0));
    check("rst_odd", 64'(odd), 64'(0));
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle();

    // Directed cases
    issue(4'd0, 8'hFE, 8'h00, 5'd5, 1'b0);   // ADD -> 03, carry
    issue(4'd7, 8'h7F, 8'h00, 5'd0, 1'b1);   // ADC -> 80, parity
    issue(4'd1, 8'h81, 8'h00, 5'd3, 1'b0);   // LSL 3 -> 08
    issue(4'd2, 8'h81, 8'h00, 5'd1, 1'b0);   // LSR 1 -> 40, carry
    issue(4'd6, 8'h00, 8'h06, 5'd0, 1'b0);   // MSK -> 40
    issue(4'd5, 8'h11, 8'h00, 5'd17, 1'b0);  // SEQ -> 1
    issue(4'd4, 8'h11, 8'h00, 5'd17, 1'b0);  // SNE -> 0
    issue(4'd3, 8'hA5, 8'h0F, 5'd0, 1'b0);   // XOR -> AA
    issue(4'd8, 8'h81, 8'h00, 5'd1, 1'b0);   // ROL or illegal depending on build
    issue(4'd9, 8'h81, 8'h00, 5'd2, 1'b0);
    issue(4'd15, 8'h81, 8'h00, 5'd1, 1'b0);  // always illegal
    issue(4'd2, 8'h81, 8'h00, 5'd1, 1'b0);   // legal op clears Err
    wait_idle();
    idle();

    // Start held during a long LSL: only the DONE-cycle request is accepted
    issue(4'd1, 8'h81, 8'h00, 5'd7, 1'b0);
    for (int i = 0; i < 14; i++) begin
      case (i % 4)
        0: op = 4'd3;
        1: op = 4'd0;
        2: op = 4'd5;
        default: op = 4'd6;
      endcase
      step(1'b1, op, W'($urandom), W'($urandom), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
    start = 1'b0;
    wait_idle();

    // Reset asserted mid-run discards the op immediately
    issue(4'd2, 8'h81, 8'h00, 5'd1, 1'b0);   // leaves Out=40
    wait_idle();
    issue(4'd1, 8'h81, 8'h00, 5'd5, 1'b0);
    idle();
    idle();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", 64'(busy), 64'(0));
    check("midrun_rst_done", 64'(done), 64'(0));
    check("midrun_rst_out", 64'(out), 64'(0));
    check("midrun_rst_zero", 64'(zero), 64'(1));
    check("midrun_rst_err", 64'(err), 64'(0));
    q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    repeat (8) idle();
    check("post_rst_busy", 64'(busy), 64'(0));

    // Randomized traffic, mostly back-to-back
    for (int i = 0; i < 250; i++) begin
      op  = 4'($urandom_range(0, 15));
      a   = W'($urandom);
      b   = W'($urandom);
      imm = 5'($urandom_range(0, 31));
      if ((op == 4'd4 || op == 4'd5) && $urandom_range(0, 1) == 1) a = W'(imm);
      if ($urandom_range(0, 3) == 0) idle();
      issue(op, a, b, imm, 1'($urandom_range(0, 1)));
    end
    wait_idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
